ram_stream_reader: RTL and testbench

//  Read-side sequencer for the single-clock simple dual-port RAM: on a Start pulse it walks Length words

---
 rtl/ram_stream_pkg.sv | 14 +
 rtl/ram_stream_skid_fifo.sv | 49 ++++
 rtl/ram_stream_reader.sv | 137 +++++++++++++
 tb/tb_ram_stream_reader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_stream_pkg.sv
// Shared definitions for the RAM stream reader: FSM state encoding and skid buffer depth.
package ram_stream_pkg;

    localparam int BUF_DEPTH = 2;
    localparam logic [1:0] OCC_FULL = 2'(BUF_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ram_stream_skid_fifo.sv
// Two-entry FIFO that catches words returning from the RAM read port.
// The caller never pushes while full or pops while empty.
module ram_stream_skid_fifo
    import ram_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_occ
);

    logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_occ;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_data = r_mem[r_rd_ptr];
    assign o_occ  = r_occ;

endmodule

// File: rtl/ram_stream_reader.sv
// Walks Length words from Base_addr through a 1-cycle-latency RAM and streams them out with valid/ready/last.
// Optional RAM_STREAM_STRIDE_EN adds a Stride______i input replacing the fixed address step of 1.
module ram_stream_reader
    import ram_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  Clock_______i,
    input  logic                  Reset_n_____i,
    input  logic                  Start_______i,
    input  logic [ADDR_WIDTH-1:0] Base_addr___i,
    input  logic [ADDR_WIDTH:0]   Length______i,
`ifdef RAM_STREAM_STRIDE_EN
    input  logic [ADDR_WIDTH-1:0] Stride______i,
`endif
    output logic                  Busy________o,
    output logic                  Done________o,
    output logic [ADDR_WIDTH-1:0] Read_address_o,
    input  logic [DATA_WIDTH-1:0] Ram_data____i,
    output logic [DATA_WIDTH-1:0] Data_out____o,
    output logic                  Valid_______o,
    input  logic                  Ready_______i,
    output logic                  Last________o
);

    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   r_issue_cnt;
    logic [ADDR_WIDTH:0]   r_pop_cnt;
    logic                  r_inflight;
    logic [ADDR_WIDTH:0]   w_last_idx;
    logic [ADDR_WIDTH-1:0] w_step;
    logic [1:0]            w_occ;
    logic [1:0]            w_pending;
    logic [DATA_WIDTH-1:0] w_fifo_data;
    logic                  w_valid;
    logic                  w_pop;
    logic                  w_issue;
    logic                  w_accept;

`ifdef RAM_STREAM_STRIDE_EN
    logic [ADDR_WIDTH-1:0] r_stride;

    always_ff @(posedge Clock_______i or negedge Reset_n_____i) begin
        if (!Reset_n_____i) begin
            r_stride <= '0;
        end else if (w_accept) begin
            r_stride <= Stride______i;
        end
    end

    assign w_step = r_stride;
`else
    assign w_step = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
`endif

    assign w_accept   = (r_state == ST_IDLE) && Start_______i;
    assign w_valid    = (w_occ != 2'd0);
    assign w_pop      = w_valid && Ready_______i;
    assign w_last_idx = r_len - CNT_ONE;
    // Buffered plus in-flight words may never exceed the FIFO depth, so a full slot only opens on a pop.
    assign w_pending  = w_occ + {1'b0, r_inflight};
    assign w_issue    = (r_state == ST_READ) &&
                        ((w_pending < OCC_FULL) || ((w_pending == OCC_FULL) && w_pop));

    always_ff @(posedge Clock_______i or negedge Reset_n_____i) begin
        if (!Reset_n_____i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (Start_______i) w_next_state = (Length______i != '0) ? ST_READ : ST_DONE;
            ST_READ:  if (w_issue && (r_issue_cnt == w_last_idx)) w_next_state = ST_DRAIN;
            ST_DRAIN: if (w_pop && (r_pop_cnt == w_last_idx)) w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        Busy________o  = (r_state != ST_IDLE);
        Done________o  = (r_state == ST_DONE);
        Valid_______o  = w_valid;
        Last________o  = w_valid && (r_pop_cnt == w_last_idx);
        Data_out____o  = w_fifo_data;
        Read_address_o = r_addr;
    end

    always_ff @(posedge Clock_______i or negedge Reset_n_____i) begin
        if (!Reset_n_____i) begin
            r_addr      <= '0;
            r_len       <= '0;
            r_issue_cnt <= '0;
            r_pop_cnt   <= '0;
            r_inflight  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr      <= Base_addr___i;
                r_len       <= Length______i;
                r_issue_cnt <= '0;
                r_pop_cnt   <= '0;
            end else begin
                if (w_issue) begin
                    r_addr      <= r_addr + w_step;
                    r_issue_cnt <= r_issue_cnt + CNT_ONE;
                end
                if (w_pop) begin
                    r_pop_cnt <= r_pop_cnt + CNT_ONE;
                end
            end
            r_inflight <= w_issue;
        end
    end

    ram_stream_skid_fifo #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fifo (
        .i_clk   (Clock_______i),
        .i_rst_n (Reset_n_____i),
        .i_push  (r_inflight),
        .i_pop   (w_pop),
        .i_data  (Ram_data____i),
        .o_data  (w_fifo_data),
        .o_occ   (w_occ)
    );

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a registered-read RAM model and an expected-word queue.
module tb_ram_stream_reader;

    localparam int DW = 12;
    localparam int AW = 6;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } expWord_t;

    logic          clk = 1'b0;
    logic          rstN;
    logic          start;
    logic          ready;
    logic [AW-1:0] baseAddr;
    logic [AW-1:0] stride;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic          valid;
    logic          last;
    logic [AW-1:0] readAddr;
    logic [DW-1:0] ramData;
    logic [DW-1:0] dataOut;
    logic          ramWe;
    logic [AW-1:0] ramWaddr;
    logic [DW-1:0] ramWdata;
    logic [DW-1:0] ramMem [2**AW];

    expWord_t expQ[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ramWe) ramMem[ramWaddr] <= ramWdata;
        ramData <= ramMem[readAddr];
    end

    ram_stream_reader #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .Clock_______i  (clk),
        .Reset_n_____i  (rstN),
        .Start_______i  (start),
        .Base_addr___i  (baseAddr),
        .Length______i  (length),
`ifdef RAM_STREAM_STRIDE_EN
        .Stride______i  (stride),
`endif
        .Busy________o  (busy),
        .Done________o  (done),
        .Read_address_o (readAddr),
        .Ram_data____i  (ramData),
        .Data_out____o  (dataOut),
        .Valid_______o  (valid),
        .Ready_______i  (ready),
        .Last________o  (last)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Pulses Start for one cycle and queues the words the RAM should return for this burst.
    task automatic applyStimulus(input logic [AW-1:0] base, input logic [AW:0] len, input logic [AW-1:0] strideVal);
        @(negedge clk);
        baseAddr = base;
        length   = len;
        stride   = strideVal;
        start    = 1'b1;
        for (int k = 0; k < int'(len); k++) begin
            int a;
            expWord_t e;
            a = (int'(base) + k * int'(strideVal)) % (2**AW);
            e.data = DW'(a + 'h100);
            e.last = (k == int'(len) - 1);
            expQ.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // readyMode 0 holds Ready high; 1 repeats 1-0-0-1.
    task automatic drainBurst(input int readyMode, input int maxCycles);
        int            cyc;
        bit            expectDone;
        bit            doneSeen;
        bit            prevStall;
        bit            streaming;
        logic [DW-1:0] prevData;
        logic          prevLast;
        expWord_t      e;
        cyc = 0; expectDone = 0; doneSeen = 0; prevStall = 0; streaming = 0;
        prevData = '0; prevLast = 1'b0;
        while (!doneSeen && cyc < maxCycles) begin
            ready = (readyMode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (expectDone) begin
                checkOutput("done_pulse", done, 1);
                doneSeen = 1;
            end else if (done) begin
                checkOutput("done_early", done, 0);
            end
            if (prevStall) begin
                checkOutput("hold_valid", valid, 1);
                checkOutput("hold_data", dataOut, prevData);
                checkOutput("hold_last", last, prevLast);
            end
            if (readyMode == 0 && streaming && !expectDone) checkOutput("no_bubble", valid, 1);
            if (valid && ready) begin
                streaming = 1;
                if (expQ.size() == 0) begin
                    checkOutput("extra_word", valid, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("data", dataOut, e.data);
                    checkOutput("last", last, e.last);
                    if (e.last) expectDone = 1;
                end
            end else if (!valid) begin
                checkOutput("last_without_valid", last, 0);
            end
            prevStall = valid && !ready;
            prevData  = dataOut;
            prevLast  = last;
            cyc++;
            @(negedge clk);
        end
        checkOutput("words_left", expQ.size(), 0);
        checkOutput("done_seen", doneSeen, 1);
        checkOutput("done_clear", done, 0);
        checkOutput("busy_clear", busy, 0);
        ready = 1'b1;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rstN = 1'b0; start = 1'b0; ready = 1'b0; baseAddr = '0; stride = '0; length = '0;
        ramWe = 1'b0; ramWaddr = '0; ramWdata = '0;
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_valid", valid, 0);
        checkOutput("rst_last", last, 0);
        checkOutput("rst_addr", readAddr, 0);
        checkOutput("rst_data", dataOut, 0);

        for (int i = 0; i < 2**AW; i++) begin
            @(negedge clk);
            ramWe = 1'b1; ramWaddr = AW'(i); ramWdata = DW'(i + 'h100);
        end
        @(negedge clk);
        ramWe = 1'b0;
        rstN  = 1'b1;

        $display("[TB] basic burst with latency check");
        ready = 1'b1;
        applyStimulus(6'd4, 7'd5, 6'd1);
        checkOutput("lat0_valid", valid, 0);
        checkOutput("busy_after_start", busy, 1);
        @(negedge clk);
        checkOutput("lat1_valid", valid, 0);
        @(negedge clk);
        checkOutput("lat2_valid", valid, 1);
        drainBurst(0, 20);

        $display("[TB] address wrap");
        applyStimulus(6'd62, 7'd4, 6'd1);
        drainBurst(0, 20);

        $display("[TB] backpressure");
        applyStimulus(6'd30, 7'd8, 6'd1);
        drainBurst(1, 60);

        $display("[TB] zero length");
        applyStimulus(6'd7, 7'd0, 6'd1);
        checkOutput("len0_done", done, 1);
        checkOutput("len0_busy", busy, 1);
        checkOutput("len0_valid", valid, 0);
        @(negedge clk);
        checkOutput("len0_done_end", done, 0);
        checkOutput("len0_busy_end", busy, 0);
        checkOutput("len0_valid_end", valid, 0);

        $display("[TB] start while busy");
        ready = 1'b0;
        applyStimulus(6'd40, 7'd5, 6'd1);
        repeat (2) @(negedge clk);
        baseAddr = 6'd10; length = 7'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drainBurst(0, 40);
        repeat (4) begin
            checkOutput("no_second_valid", valid, 0);
            checkOutput("no_second_busy", busy, 0);
            @(negedge clk);
        end

        $display("[TB] reset mid-burst");
        ready = 1'b0;
        applyStimulus(6'd0, 7'd8, 6'd1);
        repeat (3) @(negedge clk);
        ready = 1'b1;
        for (int w = 0; w < 3; w++) begin
            expWord_t e;
            e = expQ.pop_front();
            checkOutput("pre_reset_valid", valid, 1);
            checkOutput("pre_reset_data", dataOut, e.data);
            @(negedge clk);
        end
        ready = 1'b0;
        #2 rstN = 1'b0;
        #1;
        checkOutput("async_valid", valid, 0);
        checkOutput("async_busy", busy, 0);
        checkOutput("async_done", done, 0);
        checkOutput("async_last", last, 0);
        checkOutput("async_data", dataOut, 0);
        checkOutput("async_addr", readAddr, 0);
        expQ.delete();
        @(negedge clk);
        rstN = 1'b1;
        repeat (3) begin
            checkOutput("post_reset_done", done, 0);
            checkOutput("post_reset_valid", valid, 0);
            @(negedge clk);
        end
        ready = 1'b1;
        applyStimulus(6'd20, 7'd3, 6'd1);
        drainBurst(0, 30);

        $display("[TB] full-depth burst");
        applyStimulus(6'd17, 7'd64, 6'd1);
        drainBurst(0, 120);

`ifdef RAM_STREAM_STRIDE_EN
        $display("[TB] stride");
        applyStimulus(6'd60, 7'd4, 6'd3);
        drainBurst(0, 20);
        applyStimulus(6'd9, 7'd3, 6'd0);
        drainBurst(1, 40);
        applyStimulus(6'd0, 7'd64, 6'd1);
        drainBurst(0, 120);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
